// File: rtl/exec_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : exec_unit_pipe
//  Description : Execute stage with a 1-cycle ALU and an iterative shift-add
//                MUL engine. Valid/ready handshakes on both input and output.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_unit_pipe #(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_err
);

    localparam int c_SHW = $clog2(XLEN);
    localparam int c_CW  = $clog2(XLEN) + 1;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_SLT  = 4'd8;
    localparam logic [3:0] c_OP_SLTU = 4'd9;
    localparam logic [3:0] c_OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [XLEN-1:0]   r_ma;
    logic [XLEN-1:0]   r_mb;
    logic [XLEN-1:0]   r_acc;
    logic              r_valid;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;
    logic              r_err;

    logic              w_accept;
    logic              w_is_mul;
    logic              w_illegal;
    logic [c_SHW-1:0]  w_shamt;
    logic [XLEN-1:0]   w_alu;

    assign in_ready   = rst_n && ((r_state == ST_IDLE) ||
                                  (r_state == ST_HOLD && out_ready));
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (in_op == c_OP_MUL) && MUL_EN;
    assign w_illegal  = (in_op > c_OP_MUL) || ((in_op == c_OP_MUL) && !MUL_EN);
    assign w_shamt    = in_b[c_SHW-1:0];

    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_zero   = r_zero;
    assign out_err    = r_err;

    always_comb begin
        w_alu = '0;
        case (in_op)
            c_OP_ADD:  w_alu = in_a + in_b;
            c_OP_SUB:  w_alu = in_a - in_b;
            c_OP_AND:  w_alu = in_a & in_b;
            c_OP_OR:   w_alu = in_a | in_b;
            c_OP_XOR:  w_alu = in_a ^ in_b;
            c_OP_SLL:  w_alu = in_a << w_shamt;
            c_OP_SRL:  w_alu = in_a >> w_shamt;
            c_OP_SRA:  w_alu = $unsigned($signed(in_a) >>> w_shamt);
            c_OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            c_OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            default:   w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_BUSY;
                            r_cnt   <= c_CW'(XLEN);
                            r_ma    <= in_a;
                            r_mb    <= in_b;
                            r_acc   <= '0;
                            r_valid <= 1'b0;
                        end else begin
                            r_state  <= ST_HOLD;
                            r_valid  <= 1'b1;
                            r_result <= w_illegal ? '0 : w_alu;
                            r_zero   <= w_illegal ? 1'b1 : (w_alu == '0);
                            r_err    <= w_illegal;
                        end
                    end else if (r_state == ST_HOLD && out_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // One shift-add step per edge; the extra count==0 edge commits.
                    if (r_cnt != '0) begin
                        r_acc <= r_mb[0] ? (r_acc + r_ma) : r_acc;
                        r_ma  <= r_ma << 1;
                        r_mb  <= r_mb >> 1;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state  <= ST_HOLD;
                        r_valid  <= 1'b1;
                        r_result <= r_acc;
                        r_zero   <= (r_acc == '0);
                        r_err    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_unit_pipe
//  Description : Bench for exec_unit_pipe (XLEN=32, MUL on and MUL off).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_unit_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
    logic [3:0]  in_op;
    logic [31:0] in_a, in_b, out_result;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_zero1, out_err1;
    logic [3:0]  in_op1;
    logic [31:0] in_a1, in_b1, out_result1;

    exec_unit_pipe #(.XLEN(32), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_err(out_err)
    );

    exec_unit_pipe #(.XLEN(32), .MUL_EN(1'b0)) u_nomul (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_op(in_op1),
        .in_a(in_a1), .in_b(in_b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_result(out_result1), .out_zero(out_zero1), .out_err(out_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        e;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        x;
    } vec_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, req);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, b, r,
                                input logic z, e);
        vec_t v;
        v.op = op; v.a = a; v.b = b;
        v.x.res = r; v.x.z = z; v.x.e = e;
        return v;
    endfunction

    // Scoreboard: each output accept pops the oldest expected result.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output actual=%h required=none", out_result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", {out_result, out_zero, out_err}, e);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, b, input exp_t e,
                        output int waits);
        waits = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        #1;
        while (!in_ready && waits < 200) begin
            @(negedge clk); #1; waits++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end else begin
            q.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    vec_t vecs[18];
    int   w, lat, hi, cnt;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_op1 = '0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b1;

        vecs[0]  = mk(4'd0,  32'hFF00FF00, 32'h00FF00FF, 32'hFFFFFFFF, 1'b0, 1'b0);
        vecs[1]  = mk(4'd2,  32'hFF00FF00, 32'h00FF00FF, 32'h00000000, 1'b1, 1'b0);
        vecs[2]  = mk(4'd3,  32'hFF00FF00, 32'h00FF00FF, 32'hFFFFFFFF, 1'b0, 1'b0);
        vecs[3]  = mk(4'd4,  32'hFF00FF00, 32'h00FF00FF, 32'hFFFFFFFF, 1'b0, 1'b0);
        vecs[4]  = mk(4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0);
        vecs[5]  = mk(4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0);
        vecs[6]  = mk(4'd5,  32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 1'b0);
        vecs[7]  = mk(4'd5,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0);
        vecs[8]  = mk(4'd7,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0);
        vecs[9]  = mk(4'd6,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0);
        vecs[10] = mk(4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
        vecs[11] = mk(4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
        vecs[12] = mk(4'd8,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        vecs[13] = mk(4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0);
        vecs[14] = mk(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        vecs[15] = mk(4'd10, 32'h00000000, 32'h12345678, 32'h00000000, 1'b1, 1'b0);
        vecs[16] = mk(4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1);
        vecs[17] = mk(4'd15, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),   64'd0);
        chk("rst_out_valid", 64'(out_valid),  64'd0);
        chk("rst_result",    64'(out_result), 64'd0);
        chk("rst_zero",      64'(out_zero),   64'd0);
        chk("rst_err",       64'(out_err),    64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].x, w);
        drain();

        // MUL latency: busy cycles counted after the accept edge.
        send(4'd10, 32'h00001234, 32'h00000010, '{32'h00012340, 1'b0, 1'b0}, w);
        lat = 0; hi = 0;
        while (lat < 100) begin
            @(negedge clk); #1;
            if (out_valid) break;
            if (in_ready) hi++;
            lat++;
        end
        chk("mul_latency", 64'(lat), 64'd33);
        chk("mul_busy_in_ready", 64'(hi), 64'd0);
        drain();

        // Backpressure: result held for 5 cycles while a second op waits.
        @(negedge clk); out_ready = 1'b0;
        send(4'd0, 32'h00000010, 32'h00000020, '{32'h00000030, 1'b0, 1'b0}, w);
        fork
            send(4'd3, 32'h0000F000, 32'h0000000F, '{32'h0000F00F, 1'b0, 1'b0}, w);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk); #1;
                    chk("bp_valid",    64'(out_valid),  64'd1);
                    chk("bp_result",   64'(out_result), 64'h30);
                    chk("bp_in_ready", 64'(in_ready),   64'd0);
                end
                @(negedge clk); out_ready = 1'b1;
            end
        join
        chk("bp_wait_cycles", 64'(w), 64'd5);
        drain();

        // Back-to-back single-cycle ops must not introduce bubbles.
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            send(4'd0, 32'(k), 32'h100, '{32'(k) + 32'h100, 1'b0, 1'b0}, w);
            cnt += w;
        end
        chk("b2b_stalls", 64'(cnt), 64'd0);
        drain();

        // Reset in the middle of a MUL.
        send(4'd10, 32'h00001234, 32'h00000010, '{32'h00012340, 1'b0, 1'b0}, w);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_valid",    64'(out_valid),  64'd0);
        chk("midrst_in_ready", 64'(in_ready),   64'd0);
        chk("midrst_result",   64'(out_result), 64'd0);
        chk("midrst_err",      64'(out_err),    64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        repeat (40) begin @(negedge clk); #1; if (out_valid) hi++; end
        chk("midrst_no_emit", 64'(hi), 64'd0);
        send(4'd12, 32'h1, 32'h2, '{32'h0, 1'b1, 1'b1}, w);
        drain();

        // MUL disabled: op 10 is illegal with single-cycle latency.
        @(negedge clk);
        in_valid1 = 1'b1; in_op1 = 4'd10; in_a1 = 32'h3; in_b1 = 32'h5;
        #1;
        chk("nomul_in_ready", 64'(in_ready1), 64'd1);
        @(posedge clk); #1; in_valid1 = 1'b0;
        @(negedge clk); #1;
        chk("nomul_valid",  64'(out_valid1),  64'd1);
        chk("nomul_result", 64'(out_result1), 64'd0);
        chk("nomul_err",    64'(out_err1),    64'd1);
        chk("nomul_zero",   64'(out_zero1),   64'd1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
